// File: rtl/cluster_pwr_seq.sv
// Cluster power/boot sequencer: turns level requests from the control registers into an
// ordered power-ack / clock / isolation / reset handshake toward the cluster domain.
module cluster_pwr_seq #(
    parameter int CLK_CYCLES  = 4,
    parameter int RST_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cluster_pow_i,
    input  logic        cluster_byp_i,
    input  logic        cluster_fetch_enable_i,
    input  logic        cluster_rstn_i,
    input  logic [63:0] cluster_boot_addr_i,
    input  logic        pwr_ack_i,
    output logic        pwr_req_o,
    output logic        clk_en_o,
    output logic        iso_o,
    output logic        cluster_rstn_o,
    output logic        cluster_fetch_enable_o,
    output logic [63:0] cluster_boot_addr_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [3:0]  state_o
);

    localparam int MAX_DWELL = (CLK_CYCLES > RST_CYCLES) ? CLK_CYCLES : RST_CYCLES;
    localparam int MAX_CYC   = (MAX_DWELL > ACK_TIMEOUT) ? MAX_DWELL : ACK_TIMEOUT;
    localparam int CNT_W     = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLK_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_PU_WAIT = 4'd1,
        ST_CLK_ON  = 4'd2,
        ST_ISO_REL = 4'd3,
        ST_RST_REL = 4'd4,
        ST_ON      = 4'd5,
        ST_PD_RST  = 4'd6,
        ST_PD_ISO  = 4'd7,
        ST_PD_CLK  = 4'd8,
        ST_PD_WAIT = 4'd9,
        ST_ERR     = 4'd10
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ack_meta_reg, ack_s_reg;
    logic             pwr_req_reg, pwr_req_next;
    logic             clk_en_reg, clk_en_next;
    logic             iso_reg, iso_next;
    logic             rstn_reg, rstn_next;
    logic             fetch_reg, fetch_next;
    logic             busy_reg, busy_next;
    logic             err_reg, err_next;
    logic             boot_load;
    logic             start;
    logic             stop;

    assign start = cluster_pow_i & ~cluster_byp_i;
    assign stop  = ~cluster_pow_i | cluster_byp_i;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ack_meta_reg <= 1'b0;
            ack_s_reg    <= 1'b0;
            state_reg    <= ST_OFF;
            cnt_reg      <= '0;
            pwr_req_reg  <= 1'b0;
            clk_en_reg   <= 1'b0;
            iso_reg      <= 1'b1;
            rstn_reg     <= 1'b0;
            fetch_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            ack_meta_reg <= pwr_ack_i;
            ack_s_reg    <= ack_meta_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pwr_req_reg  <= pwr_req_next;
            clk_en_reg   <= clk_en_next;
            iso_reg      <= iso_next;
            rstn_reg     <= rstn_next;
            fetch_reg    <= fetch_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
        end
    end

    // Requests are only looked at in OFF/ON; every other state runs to completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_OFF:     if (start) state_next = ST_PU_WAIT;
            ST_PU_WAIT: begin
                if (ack_s_reg)                state_next = ST_CLK_ON;
                else if (cnt_reg >= ACK_LAST) state_next = ST_ERR;
            end
            ST_CLK_ON:  if (cnt_reg >= CLK_LAST) state_next = ST_ISO_REL;
            ST_ISO_REL: state_next = ST_RST_REL;
            ST_RST_REL: if (cnt_reg >= RST_LAST) state_next = ST_ON;
            ST_ON:      if (stop) state_next = ST_PD_RST;
            ST_PD_RST:  if (cnt_reg >= CLK_LAST) state_next = ST_PD_ISO;
            ST_PD_ISO:  state_next = ST_PD_CLK;
            ST_PD_CLK:  state_next = ST_PD_WAIT;
            ST_PD_WAIT: begin
                if (!ack_s_reg)               state_next = ST_OFF;
                else if (cnt_reg >= ACK_LAST) state_next = ST_ERR;
            end
            ST_ERR:     if (!cluster_pow_i && !ack_s_reg) state_next = ST_OFF;
            default:    state_next = ST_OFF;
        endcase
    end

    // Shared dwell/timeout counter: restarts on every state change, saturates otherwise.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Outputs are decoded from the state being entered so they line up with state_o.
    always_comb begin
        pwr_req_next = 1'b0;
        clk_en_next  = 1'b0;
        iso_next     = 1'b1;
        rstn_next    = 1'b0;
        fetch_next   = 1'b0;
        busy_next    = 1'b1;
        err_next     = err_reg;
        boot_load    = 1'b0;
        case (state_next)
            ST_OFF: begin
                busy_next = 1'b0;
                if (state_reg == ST_ERR) err_next = 1'b0;
            end
            ST_PU_WAIT: pwr_req_next = 1'b1;
            ST_CLK_ON: begin
                pwr_req_next = 1'b1;
                clk_en_next  = 1'b1;
            end
            ST_ISO_REL, ST_PD_RST: begin
                pwr_req_next = 1'b1;
                clk_en_next  = 1'b1;
                iso_next     = 1'b0;
            end
            ST_RST_REL: begin
                pwr_req_next = 1'b1;
                clk_en_next  = 1'b1;
                iso_next     = 1'b0;
                boot_load    = (state_reg != ST_RST_REL);
            end
            ST_ON: begin
                pwr_req_next = 1'b1;
                clk_en_next  = 1'b1;
                iso_next     = 1'b0;
                busy_next    = 1'b0;
                rstn_next    = cluster_rstn_i;
                // Fetch is held off on the entry cycle so cores see reset released first.
                fetch_next   = (state_reg == ST_ON) & cluster_fetch_enable_i & cluster_rstn_i;
            end
            ST_PD_ISO: begin
                pwr_req_next = 1'b1;
                clk_en_next  = 1'b1;
            end
            ST_PD_CLK:  pwr_req_next = 1'b1;
            ST_PD_WAIT: busy_next = 1'b1;
            ST_ERR: begin
                busy_next = 1'b0;
                err_next  = 1'b1;
            end
            default:    busy_next = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_boot_core
            logic [31:0] boot_half_reg;
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    boot_half_reg <= 32'd0;
                end else if (boot_load) begin
                    boot_half_reg <= cluster_boot_addr_i[gi*32 +: 32];
                end
            end
            assign cluster_boot_addr_o[gi*32 +: 32] = boot_half_reg;
        end
    endgenerate

    assign pwr_req_o              = pwr_req_reg;
    assign clk_en_o               = clk_en_reg;
    assign iso_o                  = iso_reg;
    assign cluster_rstn_o         = rstn_reg;
    assign cluster_fetch_enable_o = fetch_reg;
    assign busy_o                 = busy_reg;
    assign err_o                  = err_reg;
    assign state_o                = state_reg;

endmodule
